tnn_infer_sequencer: RTL and testbench

- Sequential front-end for the 2-bit-input approximate TNN classifier core, which is purely combinational: 7 features, 2 bits each, 1-bit class output.
- Accepts features serially over a valid/ready stream and assembles them into the core's packed input vector.
- Waits a configurable settle/pipeline latency, captures the class bit, and returns it on a valid/ready result port with a framing-error flag.
- Sits between the sensor/feature stream and the classifier core instance in the inference top level.

---
 rtl/tnn_seq_pkg.sv | 22 ++
 rtl/tnn_sat_counter.sv | 46 ++++
 rtl/tnn_infer_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_tnn_infer_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tnn_seq_pkg.sv
// -----------------------------------------------------------------------------
// tnn_seq_pkg
// Shared types and default sizes for the TNN inference sequencer.
//   seq_state_t : sequencer FSM states (LOAD, DRAIN, EVAL, HOLD)
//   N_FEAT_DEF  : default number of features per sample
//   FEAT_W_DEF  : default bits per feature
//   VEC_W       : width of the packed core input vector at the defaults
// -----------------------------------------------------------------------------
package tnn_seq_pkg;

    localparam int N_FEAT_DEF = 7;
    localparam int FEAT_W_DEF = 2;
    localparam int VEC_W      = N_FEAT_DEF * FEAT_W_DEF;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        EVAL  = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/tnn_sat_counter.sv
// -----------------------------------------------------------------------------
// tnn_sat_counter
// Up-counter that sticks at all-ones. Clear wins over increment.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clr        : synchronous clear
//   inc        : increment enable
//   count      : current count value
// -----------------------------------------------------------------------------
module tnn_sat_counter
    import tnn_seq_pkg::*;
#(
    parameter int W = 16
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != '1)) begin
            count_next = count_reg + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/tnn_infer_sequencer.sv
// -----------------------------------------------------------------------------
// tnn_infer_sequencer
// Serial front-end for the combinational 2-bit-input TNN classifier core.
// Collects N_FEAT feature beats into the core's packed input vector, waits
// CORE_LAT+1 cycles for the core to settle, captures the class bit and offers
// it on a valid/ready result port together with a framing-error flag.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_valid/s_ready     : feature stream handshake
//   s_data, s_last      : feature value, final beat of the sample
//   core_vec            : packed vector to the core (feature 0 at the LSBs)
//   core_class          : class bit from the core
//   m_valid/m_ready     : result handshake
//   m_class, m_err      : captured class bit, framing error of that sample
//   busy                : low only when idle in LOAD with no beat collected
// Optional (macro TNN_SEQ_STATS_EN):
//   stat_clr            : synchronous clear of both statistics counters
//   stat_total          : error-free results delivered (saturating)
//   stat_pos            : error-free results with class 1 (saturating)
// -----------------------------------------------------------------------------
module tnn_infer_sequencer
    import tnn_seq_pkg::*;
#(
    parameter int N_FEAT   = N_FEAT_DEF,
    parameter int FEAT_W   = FEAT_W_DEF,
    parameter int CORE_LAT = 0,
    parameter int CNT_W    = 16
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [FEAT_W-1:0]          s_data,
    input  logic                       s_last,
    output logic [N_FEAT*FEAT_W-1:0]   core_vec,
    input  logic                       core_class,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_class,
    output logic                       m_err,
    output logic                       busy
`ifdef TNN_SEQ_STATS_EN
    ,
    input  logic                       stat_clr,
    output logic [CNT_W-1:0]           stat_total,
    output logic [CNT_W-1:0]           stat_pos
`endif
);

    localparam int                CNT_BITS  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [CNT_BITS-1:0] LAST_SLOT = CNT_BITS'(N_FEAT - 1);
    localparam int                LAT_W     = 3;
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(CORE_LAT);

    if (CORE_LAT < 0 || CORE_LAT > 7) begin : g_bad_lat
        $error("CORE_LAT must lie in 0..7");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    seq_state_t           state_reg, state_next;
    logic [CNT_BITS-1:0]  cnt_reg, cnt_next;
    logic                 err_reg, err_next;
    logic                 m_valid_reg, m_valid_next;
    logic                 m_class_reg, m_class_next;
    logic                 m_err_reg, m_err_next;
    logic                 beat_wr;
    logic                 eval_last;
    logic [LAT_W-1:0]     wait_cnt;

    // EVAL dwell counter: held at zero outside EVAL and cleared on the final
    // EVAL cycle so every evaluation starts from zero. It never reaches its
    // saturation point because CORE_LAT is at most 7.
    tnn_sat_counter #(.W(LAT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state_reg != EVAL) || eval_last),
        .inc   (1'b1),
        .count (wait_cnt)
    );

    assign eval_last = (state_reg == EVAL) && (wait_cnt == LAT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= LOAD;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            m_valid_reg <= 1'b0;
            m_class_reg <= 1'b0;
            m_err_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            err_reg     <= err_next;
            m_valid_reg <= m_valid_next;
            m_class_reg <= m_class_next;
            m_err_reg   <= m_err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        err_next     = err_reg;
        m_valid_next = m_valid_reg;
        m_class_next = m_class_reg;
        m_err_next   = m_err_reg;
        beat_wr      = 1'b0;
        case (state_reg)
            LOAD: begin
                if (s_valid) begin
                    beat_wr = 1'b1;
                    if (cnt_reg == LAST_SLOT) begin
                        // cnt parks on the last slot instead of wrapping.
                        if (s_last) begin
                            state_next = EVAL;
                        end else begin
                            err_next   = 1'b1;
                            state_next = DRAIN;
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_BITS'(1);
                        if (s_last) begin
                            // Short sample: remaining slots keep stale data.
                            err_next   = 1'b1;
                            state_next = EVAL;
                        end
                    end
                end
            end
            DRAIN: begin
                if (s_valid && s_last) begin
                    state_next = EVAL;
                end
            end
            EVAL: begin
                if (eval_last) begin
                    m_class_next = core_class;
                    m_err_next   = err_reg;
                    m_valid_next = 1'b1;
                    state_next   = HOLD;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    m_valid_next = 1'b0;
                    cnt_next     = '0;
                    err_next     = 1'b0;
                    state_next   = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // One register per feature slot; only an accepted LOAD beat aimed at the
    // slot can change it, so DRAIN and EVAL leave core_vec untouched.
    for (genvar gi = 0; gi < N_FEAT; gi++) begin : g_slot
        logic [FEAT_W-1:0] slot_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_reg <= '0;
            end else if (beat_wr && (cnt_reg == CNT_BITS'(gi))) begin
                slot_reg <= s_data;
            end
        end

        assign core_vec[gi*FEAT_W +: FEAT_W] = slot_reg;
    end

    // Gated with rst_n so the stream is refused while reset is held.
    assign s_ready = rst_n && ((state_reg == LOAD) || (state_reg == DRAIN));
    assign busy    = !((state_reg == LOAD) && (cnt_reg == '0));
    assign m_valid = m_valid_reg;
    assign m_class = m_class_reg;
    assign m_err   = m_err_reg;

`ifdef TNN_SEQ_STATS_EN
    logic result_ok;

    assign result_ok = m_valid_reg && m_ready && !m_err_reg;

    tnn_sat_counter #(.W(CNT_W)) u_stat_total (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (result_ok),
        .count (stat_total)
    );

    tnn_sat_counter #(.W(CNT_W)) u_stat_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (result_ok && m_class_reg),
        .count (stat_pos)
    );
`endif

endmodule

// File: tb/tb_tnn_infer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tnn_infer_sequencer
// Two sequencers (CORE_LAT=0 and CORE_LAT=3) share one feature stream and one
// m_ready. Each has its own core model: class = LSB of feature 6, seen
// combinationally by unit 0 and through a 3-cycle delay by unit 1. Expected
// results are queued per unit when a sample is sent and compared when the
// unit raises m_valid. Build with TNN_SEQ_STATS_EN to also exercise the
// statistics counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tnn_infer_sequencer;
    import tnn_seq_pkg::*;

    localparam int NF = N_FEAT_DEF;
    localparam int FW = FEAT_W_DEF;
    localparam int VW = VEC_W;

    typedef struct packed {
        logic          cls;
        logic          err;
        logic [VW-1:0] vec;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          s_valid;
    logic [FW-1:0] s_data;
    logic          s_last;
    logic          m_ready;
    logic [1:0]    s_ready_w, m_valid_w, m_class_w, m_err_w, busy_w;
    logic [VW-1:0] core_vec0, core_vec1;
    logic          core_class0, core_class1;
    logic [VW-1:0] dly1, dly2, dly3;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    exp_t          q0[$];
    exp_t          q1[$];
    logic [FW-1:0] mslot [NF];
    bit            hold_f [2];
    bit            done_f [2];
    exp_t          cur_e  [2];
    int            last_k [2];

    function automatic logic core_fn(input logic [VW-1:0] v);
        return v[12];
    endfunction

    assign core_class0 = core_fn(core_vec0);
    assign core_class1 = core_fn(dly3);

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        dly1 <= core_vec1;
        dly2 <= dly1;
        dly3 <= dly2;
    end

`ifdef TNN_SEQ_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_total0, stat_pos0, stat_total1, stat_pos1;
`endif

    tnn_infer_sequencer #(.CORE_LAT(0)) u0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready_w[0]),
        .s_data     (s_data),
        .s_last     (s_last),
        .core_vec   (core_vec0),
        .core_class (core_class0),
        .m_valid    (m_valid_w[0]),
        .m_ready    (m_ready),
        .m_class    (m_class_w[0]),
        .m_err      (m_err_w[0]),
        .busy       (busy_w[0])
`ifdef TNN_SEQ_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_total (stat_total0),
        .stat_pos   (stat_pos0)
`endif
    );

    tnn_infer_sequencer #(.CORE_LAT(3)) u1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready_w[1]),
        .s_data     (s_data),
        .s_last     (s_last),
        .core_vec   (core_vec1),
        .core_class (core_class1),
        .m_valid    (m_valid_w[1]),
        .m_ready    (m_ready),
        .m_class    (m_class_w[1]),
        .m_err      (m_err_w[1]),
        .busy       (busy_w[1])
`ifdef TNN_SEQ_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_total (stat_total1),
        .stat_pos   (stat_pos1)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [VW-1:0] model_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < NF; i++) v[i*FW +: FW] = mslot[i];
        return v;
    endfunction

    // Result-side monitor for unit d, sampled on the falling edge.
    task automatic mon(input int d);
        logic          mv, mc, me, sr, bz;
        logic [VW-1:0] cv;
        exp_t          e;
        int            qsz;
        mv = m_valid_w[d];
        mc = m_class_w[d];
        me = m_err_w[d];
        sr = s_ready_w[d];
        bz = busy_w[d];
        cv = (d == 0) ? core_vec0 : core_vec1;
        if (!rst_n) begin
            hold_f[d] = 1'b0;
            done_f[d] = 1'b0;
            return;
        end
        if (s_valid && s_last && sr) last_k[d] = cyc;
        if (done_f[d]) begin
            check_val($sformatf("u%0d_after_hs_valid", d), 32'(mv), 32'd0);
            check_val($sformatf("u%0d_after_hs_ready", d), 32'(sr), 32'd1);
            check_val($sformatf("u%0d_after_hs_busy", d), 32'(bz), 32'd0);
            done_f[d] = 1'b0;
        end
        if (mv) begin
            if (!hold_f[d]) begin
                hold_f[d] = 1'b1;
                qsz = (d == 0) ? q0.size() : q1.size();
                if (qsz == 0) begin
                    check_val($sformatf("u%0d_sb_nonempty", d), 32'(qsz), 32'd1);
                    e = '0;
                end else if (d == 0) begin
                    e = q0.pop_front();
                end else begin
                    e = q1.pop_front();
                end
                cur_e[d] = e;
                $display("result u%0d cycle=%0d class=%0d err=%0d vec=%h lat=%0d",
                         d, cyc, mc, me, cv, cyc - last_k[d]);
                check_val($sformatf("u%0d_latency", d), 32'(cyc - last_k[d]), (d == 0) ? 32'd2 : 32'd5);
                check_val($sformatf("u%0d_class", d), 32'(mc), 32'(e.cls));
                check_val($sformatf("u%0d_err", d), 32'(me), 32'(e.err));
                check_val($sformatf("u%0d_vec", d), 32'(cv), 32'(e.vec));
            end else begin
                check_val($sformatf("u%0d_hold_class", d), 32'(mc), 32'(cur_e[d].cls));
                check_val($sformatf("u%0d_hold_err", d), 32'(me), 32'(cur_e[d].err));
                check_val($sformatf("u%0d_hold_vec", d), 32'(cv), 32'(cur_e[d].vec));
                check_val($sformatf("u%0d_hold_ready", d), 32'(sr), 32'd0);
            end
            if (m_ready) begin
                hold_f[d] = 1'b0;
                done_f[d] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(busy_w == 2'b00 && s_ready_w == 2'b11) && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) check_val("timeout_idle", 32'(busy_w), 32'd0);
    endtask

    task automatic wait_hold();
        int t = 0;
        while (m_valid_w != 2'b11 && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) check_val("timeout_hold", 32'(m_valid_w), 32'd3);
    endtask

    // Sends n beats (beat i = pb[2i+:2]), s_last on the final one, and queues
    // the expected result for both units.
    task automatic send_sample(input int n, input logic [31:0] pb, input bit stall);
        exp_t e;
        int   t;
        wait_idle();
        for (int i = 0; i < n; i++) begin
            if (stall) repeat ($urandom_range(0, 2)) tick();
            s_valid = 1'b1;
            s_data  = pb[2*i +: 2];
            s_last  = (i == n - 1);
            t = 0;
            while (s_ready_w != 2'b11 && t < 50) begin
                tick();
                t++;
            end
            if (t >= 50) check_val("timeout_ready", 32'(s_ready_w), 32'd3);
            tick();
            if (i < NF) mslot[i] = pb[2*i +: 2];
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
        e.vec = model_vec();
        e.err = (n != NF);
        e.cls = core_fn(e.vec);
        q0.push_back(e);
        q1.push_back(e);
        $display("sample beats=%0d vec=%h exp_class=%0d exp_err=%0d", n, e.vec, e.cls, e.err);
    endtask

    task automatic reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        check_val({tag, "_m_valid"}, 32'(m_valid_w), 32'd0);
        check_val({tag, "_m_class"}, 32'(m_class_w), 32'd0);
        check_val({tag, "_m_err"},   32'(m_err_w),   32'd0);
        check_val({tag, "_s_ready"}, 32'(s_ready_w), 32'd0);
        check_val({tag, "_busy"},    32'(busy_w),    32'd0);
        check_val({tag, "_vec0"},    32'(core_vec0), 32'd0);
        check_val({tag, "_vec1"},    32'(core_vec1), 32'd0);
        q0.delete();
        q1.delete();
        for (int i = 0; i < NF; i++) mslot[i] = '0;
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        check_val({tag, "_rel_ready"}, 32'(s_ready_w), 32'd3);
    endtask

    localparam logic [31:0] SAMPLE_A  = 32'h0001_1B1B; // 3,2,1,0,3,2,1
    localparam logic [31:0] SAMPLE_SH = 32'h0000_0024; // 0,1,2
    localparam logic [31:0] SAMPLE_LG = 32'h0003_C555; // 1,1,1,1,1,1,0,3,3
    localparam logic [31:0] SAMPLE_CL = 32'h0000_3AAA; // 2,2,2,2,2,2,3

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < NF; i++) mslot[i] = '0;
`ifdef TNN_SEQ_STATS_EN
        stat_clr = 1'b0;
`endif
        #12;
        check_val("rst_s_ready", 32'(s_ready_w), 32'd0);
        check_val("rst_m_valid", 32'(m_valid_w), 32'd0);
        check_val("rst_m_class", 32'(m_class_w), 32'd0);
        check_val("rst_m_err",   32'(m_err_w),   32'd0);
        check_val("rst_busy",    32'(busy_w),    32'd0);
        check_val("rst_vec",     32'(core_vec0), 32'd0);
        #10;
        rst_n = 1'b1;
        tick();
        check_val("load_s_ready", 32'(s_ready_w), 32'd3);

        // Full sample, result consumed as soon as it appears.
        m_ready = 1'b1;
        send_sample(7, SAMPLE_A, 1'b0);
        check_val("vec_1b1b", 32'(core_vec0), 32'h1B1B);
        wait_idle();

        // Same sample, result held off for 5 cycles.
        m_ready = 1'b0;
        send_sample(7, SAMPLE_A, 1'b0);
        wait_hold();
        repeat (5) tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        wait_idle();

        // Short sample with stalls: slots 3..6 keep the previous data.
        m_ready = 1'b1;
        send_sample(3, SAMPLE_SH, 1'b1);
        wait_idle();

        // Long sample: beats 8 and 9 are drained.
        send_sample(9, SAMPLE_LG, 1'b1);
        wait_idle();

        // Class goes 0 -> 1 on the final beat; unit 1 must wait for its core.
        send_sample(7, SAMPLE_CL, 1'b0);
        wait_idle();

`ifdef TNN_SEQ_STATS_EN
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        repeat (3) send_sample(7, SAMPLE_A, 1'b0);
        send_sample(3, SAMPLE_SH, 1'b0);
        wait_idle();
        tick();
        check_val("stat_total0", 32'(stat_total0), 32'd3);
        check_val("stat_pos0",   32'(stat_pos0),   32'd3);
        check_val("stat_total1", 32'(stat_total1), 32'd3);
        check_val("stat_pos1",   32'(stat_pos1),   32'd3);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check_val("stat_clr_total0", 32'(stat_total0), 32'd0);
        check_val("stat_clr_pos1",   32'(stat_pos1),   32'd0);
`endif

        // Reset while both units evaluate.
        m_ready = 1'b0;
        send_sample(7, SAMPLE_CL, 1'b0);
        reset_check("rst_eval");

        // Reset while both units hold a result.
        send_sample(7, SAMPLE_A, 1'b0);
        wait_hold();
        reset_check("rst_hold");

        // Recovery: a short sample now sees zeroed stale slots.
        m_ready = 1'b1;
        send_sample(3, SAMPLE_SH, 1'b1);
        wait_idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule
